// File: rtl/pe_operand_loader.sv
// pe_operand_loader
//   Feeds the pe_8x4_16bit compute array from a single DW-bit word stream.
//   After a load_w pulse, NIN*NOUT words fill the weight bank (WEIGHT), then
//   the loader runs continuously, gathering NIN-word data vectors into a
//   shadow buffer and committing each complete vector to DATA with a
//   one-cycle ce pulse. Because of the shadow buffer, the next vector can
//   stream in while the PE works on the current one.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high
//   s_data    in   stream word
//   s_valid   in   stream word valid
//   s_ready   out  loader accepts word (transfer on s_valid & s_ready)
//   load_w    in   single-cycle pulse: (re)load the weight bank
//   hold      in   PE busy: back-pressures only the vector-completing word
//   DATA      out  DW*NIN data vector, word i at [i*DW +: DW]
//   WEIGHT    out  DW*NIN*NOUT weight bank, word k at [k*DW +: DW]
//   ce        out  one-cycle pulse aligned with newly committed DATA
//   w_loaded  out  weight bank complete and valid
//   vec_cnt   out  (only with PE_LOADER_VECCNT_EN) ce pulses since the last
//                  weight-bank completion, saturating at 16'hFFFF
//
// Optional feature macro: PE_LOADER_VECCNT_EN
module pe_operand_loader #(
  parameter int DW   = 16,
  parameter int NIN  = 8,
  parameter int NOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   load_w,
  input  logic                   hold,
  output logic [DW*NIN-1:0]      DATA,
  output logic [DW*NIN*NOUT-1:0] WEIGHT,
  output logic                   ce,
  output logic                   w_loaded
`ifdef PE_LOADER_VECCNT_EN
  ,
  output logic [15:0]            vec_cnt
`endif
);

  localparam int NW  = NIN * NOUT;
  localparam int WCW = $clog2(NW);
  localparam int DCW = $clog2(NIN);
  localparam logic [WCW-1:0] WC_LAST = WCW'(NW - 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(NIN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   next_state_s;
  logic [WCW-1:0]           wc_r;
  logic [DCW-1:0]           dc_r;
  // Slot NIN-1 never lands in the shadow: the completing word goes
  // straight into DATA.
  logic [DW*(NIN-1)-1:0]    shadow_r;
  logic [DW*NIN-1:0]        data_r;
  logic [DW*NW-1:0]         weight_r;
  logic                     ce_r;
  logic                     w_loaded_r;
  logic                     s_ready_s;
  logic                     xfer_s;
  logic                     w_done_s;
  logic                     commit_s;

  assign xfer_s   = s_valid & s_ready_s;
  // Last weight word accepted: bank complete.
  assign w_done_s = (state_r == ST_LOAD_W) & xfer_s & (wc_r == WC_LAST);
  // Vector-completing word accepted; load_w in RUN always wins over a commit.
  assign commit_s = (state_r == ST_RUN) & ~load_w & xfer_s & (dc_r == DC_LAST);

  // Stream handshake: only the vector-completing word sees hold, and a
  // load_w in RUN refuses the word so the abandoned vector cannot complete.
  always_comb begin
    s_ready_s = 1'b0;
    case (state_r)
      ST_IDLE:   s_ready_s = 1'b0;
      ST_LOAD_W: s_ready_s = 1'b1;
      ST_RUN:    s_ready_s = ~load_w & ~(hold & (dc_r == DC_LAST));
      default:   s_ready_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_w) next_state_s = ST_LOAD_W;
        else        next_state_s = ST_IDLE;
      end
      ST_LOAD_W: begin
        if (w_done_s) next_state_s = ST_RUN;
        else          next_state_s = ST_LOAD_W;
      end
      ST_RUN: begin
        if (load_w) next_state_s = ST_LOAD_W;
        else        next_state_s = ST_RUN;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Counters, weight bank, shadow buffer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wc_r       <= '0;
      dc_r       <= '0;
      shadow_r   <= '0;
      data_r     <= '0;
      weight_r   <= '0;
      ce_r       <= 1'b0;
      w_loaded_r <= 1'b0;
    end else begin
      ce_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load_w) wc_r <= '0;
        end
        ST_LOAD_W: begin
          if (xfer_s) begin
            weight_r[wc_r*DW +: DW] <= s_data;
            if (wc_r == WC_LAST) begin
              wc_r       <= '0;
              dc_r       <= '0;
              w_loaded_r <= 1'b1;
            end else begin
              wc_r <= wc_r + WCW'(1);
            end
          end
        end
        ST_RUN: begin
          if (load_w) begin
            // Abandon any partial vector; the shadow is simply overwritten later.
            dc_r       <= '0;
            wc_r       <= '0;
            w_loaded_r <= 1'b0;
          end else if (xfer_s) begin
            if (dc_r == DC_LAST) begin
              data_r <= {s_data, shadow_r};
              dc_r   <= '0;
              ce_r   <= 1'b1;
            end else begin
              shadow_r[dc_r*DW +: DW] <= s_data;
              dc_r <= dc_r + DCW'(1);
            end
          end
        end
        default: begin
          wc_r <= '0;
          dc_r <= '0;
        end
      endcase
    end
  end

`ifdef PE_LOADER_VECCNT_EN
  logic [15:0] vec_cnt_r;

  // Vectors issued since the weight bank last completed, saturating.
  always_ff @(posedge clk) begin
    if (rst)                                      vec_cnt_r <= 16'h0000;
    else if (w_done_s)                            vec_cnt_r <= 16'h0000;
    else if (commit_s && vec_cnt_r != 16'hFFFF)   vec_cnt_r <= vec_cnt_r + 16'h0001;
    else                                          vec_cnt_r <= vec_cnt_r;
  end

  assign vec_cnt = vec_cnt_r;
`endif

  assign s_ready  = s_ready_s;
  assign DATA     = data_r;
  assign WEIGHT   = weight_r;
  assign ce       = ce_r;
  assign w_loaded = w_loaded_r;

endmodule

// File: tb/tb_pe_operand_loader.sv
// Directed testbench for pe_operand_loader (DW=16, NIN=8, NOUT=4).
module tb_pe_operand_loader;

  localparam int DW   = 16;
  localparam int NIN  = 8;
  localparam int NOUT = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DW-1:0]          s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   load_w;
  logic                   hold;
  logic [DW*NIN-1:0]      DATA;
  logic [DW*NIN*NOUT-1:0] WEIGHT;
  logic                   ce;
  logic                   w_loaded;
`ifdef PE_LOADER_VECCNT_EN
  logic [15:0]            vec_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW*NIN-1:0]      exp_d;
  logic [DW*NIN*NOUT-1:0] exp_w;

  always #5 clk = ~clk;

  pe_operand_loader #(.DW(DW), .NIN(NIN), .NOUT(NOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .load_w   (load_w),
    .hold     (hold),
    .DATA     (DATA),
    .WEIGHT   (WEIGHT),
    .ce       (ce),
    .w_loaded (w_loaded)
`ifdef PE_LOADER_VECCNT_EN
    ,
    .vec_cnt  (vec_cnt)
`endif
  );

  // Advance past the next rising edge; inputs change and outputs are read here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_w = 1'b0; hold = 1'b0; s_valid = 1'b0; s_data = 16'h0000;
    cyc(); cyc();
    total_cnt++; if (DATA !== '0) $display("FAIL reset_data: got %h want 0", DATA); else pass_cnt++;
    total_cnt++; if (WEIGHT !== '0) $display("FAIL reset_weight: got %h want 0", WEIGHT); else pass_cnt++;
    total_cnt++; if (ce !== 1'b0) $display("FAIL reset_ce: got %b want 0", ce); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else pass_cnt++;
    total_cnt++; if (w_loaded !== 1'b0) $display("FAIL reset_w_loaded: got %b want 0", w_loaded); else pass_cnt++;
  endtask

  task automatic test_load_weights();
    int nready = 0;
    int nbad   = 0;
    rst = 1'b0;
    cyc();
    load_w = 1'b1;
    cyc();
    load_w = 1'b0;
    for (int k = 0; k < NIN*NOUT; k++) begin
      s_valid = 1'b1; s_data = 16'h2F04;
      #1;
      if (s_ready !== 1'b1) nready++;
      if (ce !== 1'b0 || w_loaded !== 1'b0) nbad++;
      cyc();
    end
    s_valid = 1'b0;
    total_cnt++; if (nready != 0) $display("FAIL wload_ready: %0d cycles not ready, want 0", nready); else pass_cnt++;
    total_cnt++; if (nbad != 0) $display("FAIL wload_ce_wloaded: %0d bad cycles, want 0", nbad); else pass_cnt++;
    total_cnt++; if (w_loaded !== 1'b1) $display("FAIL wload_done: got %b want 1", w_loaded); else pass_cnt++;
    exp_w = {32{16'h2F04}};
    total_cnt++; if (WEIGHT !== exp_w) $display("FAIL wload_weight: got %h want %h", WEIGHT, exp_w); else pass_cnt++;
    total_cnt++; if (DATA !== '0) $display("FAIL wload_data: got %h want 0", DATA); else pass_cnt++;
    total_cnt++; if (ce !== 1'b0) $display("FAIL wload_ce: got %b want 0", ce); else pass_cnt++;
  endtask

  task automatic test_single_vector();
    int nce = 0;
    for (int i = 0; i < NIN; i++) begin
      s_valid = 1'b1; s_data = 16'h0B2A;
      #1;
      if (ce !== 1'b0) nce++;
      cyc();
    end
    s_valid = 1'b0;
    exp_d = {8{16'h0B2A}};
    total_cnt++; if (nce != 0) $display("FAIL vec1_early_ce: %0d early pulses, want 0", nce); else pass_cnt++;
    total_cnt++; if (ce !== 1'b1) $display("FAIL vec1_ce: got %b want 1", ce); else pass_cnt++;
    total_cnt++; if (DATA !== exp_d) $display("FAIL vec1_data: got %h want %h", DATA, exp_d); else pass_cnt++;
    cyc();
    total_cnt++; if (ce !== 1'b0) $display("FAIL vec1_ce_width: got %b want 0", ce); else pass_cnt++;
    total_cnt++; if (DATA !== exp_d) $display("FAIL vec1_data_hold: got %h want %h", DATA, exp_d); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic exp_ce;
    int   nready = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      #1;
      if (s_ready !== 1'b1) nready++;
      cyc();
      if (i % 8 == 7) begin
        for (int j = 0; j < NIN; j++) exp_d[j*DW +: DW] = 16'(i - 7 + j);
        exp_ce = 1'b1;
      end else begin
        exp_ce = 1'b0;
      end
      total_cnt++;
      if (ce !== exp_ce || DATA !== exp_d)
        $display("FAIL ramp_%0d: got ce=%b data=%h want ce=%b data=%h", i, ce, DATA, exp_ce, exp_d);
      else pass_cnt++;
    end
    s_valid = 1'b0;
    total_cnt++; if (nready != 0) $display("FAIL ramp_ready: %0d stalls, want 0", nready); else pass_cnt++;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = 16'h00A0 + 16'(i); hold = 1'b0;
      cyc();
    end
    hold = 1'b1; s_data = 16'h00A7;
    #1;
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL hold_ready: got %b want 0", s_ready); else pass_cnt++;
    cyc();
    total_cnt++; if (ce !== 1'b0 || DATA !== exp_d) $display("FAIL hold_stall1: got ce=%b data=%h want ce=0 data=%h", ce, DATA, exp_d); else pass_cnt++;
    cyc();
    total_cnt++; if (ce !== 1'b0 || s_ready !== 1'b0) $display("FAIL hold_stall2: got ce=%b ready=%b want 0 0", ce, s_ready); else pass_cnt++;
    hold = 1'b0;
    #1;
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL hold_release_ready: got %b want 1", s_ready); else pass_cnt++;
    cyc();
    s_valid = 1'b0;
    for (int j = 0; j < NIN; j++) exp_d[j*DW +: DW] = 16'h00A0 + 16'(j);
    total_cnt++; if (ce !== 1'b1 || DATA !== exp_d) $display("FAIL hold_commit: got ce=%b data=%h want ce=1 data=%h", ce, DATA, exp_d); else pass_cnt++;
    cyc();
    total_cnt++; if (ce !== 1'b0) $display("FAIL hold_ce_width: got %b want 0", ce); else pass_cnt++;
  endtask

  task automatic test_reload();
    int nce = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'h00C0 + 16'(i);
      cyc();
    end
    s_valid = 1'b0; load_w = 1'b1;
    cyc();
    load_w = 1'b0;
    total_cnt++; if (w_loaded !== 1'b0 || ce !== 1'b0) $display("FAIL reload_abort: got w_loaded=%b ce=%b want 0 0", w_loaded, ce); else pass_cnt++;
    for (int k = 0; k < NIN*NOUT; k++) begin
      s_valid = 1'b1; s_data = 16'h1000 + 16'(k);
      exp_w[k*DW +: DW] = 16'h1000 + 16'(k);
      #1;
      if (ce !== 1'b0 || w_loaded !== 1'b0) nce++;
      cyc();
    end
    total_cnt++; if (w_loaded !== 1'b1) $display("FAIL reload_done: got %b want 1", w_loaded); else pass_cnt++;
    total_cnt++; if (WEIGHT !== exp_w) $display("FAIL reload_weight: got %h want %h", WEIGHT, exp_w); else pass_cnt++;
    total_cnt++; if (DATA !== exp_d) $display("FAIL reload_data_kept: got %h want %h", DATA, exp_d); else pass_cnt++;
    for (int i = 0; i < NIN; i++) begin
      s_valid = 1'b1; s_data = 16'h00D0 + 16'(i);
      #1;
      if (ce !== 1'b0) nce++;
      cyc();
    end
    s_valid = 1'b0;
    for (int j = 0; j < NIN; j++) exp_d[j*DW +: DW] = 16'h00D0 + 16'(j);
    total_cnt++; if (nce != 0) $display("FAIL reload_early_ce: %0d bad cycles, want 0", nce); else pass_cnt++;
    total_cnt++; if (ce !== 1'b1 || DATA !== exp_d) $display("FAIL reload_vec: got ce=%b data=%h want ce=1 data=%h", ce, DATA, exp_d); else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    int nbad = 0;
    cyc();
    load_w = 1'b1;
    cyc();
    load_w = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1; s_data = 16'h5555;
      cyc();
    end
    rst = 1'b1; s_valid = 1'b0;
    cyc();
    total_cnt++;
    if (DATA !== '0 || WEIGHT !== '0 || ce !== 1'b0 || s_ready !== 1'b0 || w_loaded !== 1'b0)
      $display("FAIL midrst_outputs: got ce=%b ready=%b w_loaded=%b data=%h want all 0", ce, s_ready, w_loaded, DATA);
    else pass_cnt++;
    rst = 1'b0; s_valid = 1'b1; s_data = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (s_ready !== 1'b0 || w_loaded !== 1'b0) nbad++;
      cyc();
    end
    s_valid = 1'b0;
    total_cnt++; if (nbad != 0) $display("FAIL midrst_idle: %0d bad cycles, want 0", nbad); else pass_cnt++;
    total_cnt++; if (WEIGHT !== '0) $display("FAIL midrst_weight: got %h want 0", WEIGHT); else pass_cnt++;
  endtask

  initial begin
    exp_d = '0;
    exp_w = '0;
    test_reset();
    test_load_weights();
    test_single_vector();
    test_back_to_back();
    test_hold();
    test_reload();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
